i2c_controller_read: RTL and testbench

I2C read master for the LM32 SoC's wishbone I2C peripheral. On `start` it performs a register read: START, 7-bit device address with W, 8-bit register pointer, repeated START, device address with R, one data byte received, master NACK, STOP. The returned byte and the slave ack status are exposed to the wishbone wrapper. Bit timing and the SCL/SDA drive scheme match the existing I2C write controller, so both can share one bus through the wrapper's mux.

---
 rtl/i2c_controller_read.sv | 129 ++++++++++++
 tb/tb_i2c_controller_read.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_controller_read.sv
// i2c_controller_read: I2C register-read master (START, addr+W, pointer, Sr, addr+R, one byte, NACK, STOP).
// Optional I2C_RD_NACK_ABORT_EN: a slave NACK on any address/pointer byte jumps straight to STOP.
module i2c_controller_read #(
  parameter logic [5:0] LAST_STAGE = 6'd41
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] i2c_data,
  output logic        i2c_sclk,
  inout  wire         i2c_sdat,
  output logic [7:0]  rd_data,
  output logic        done,
  output logic        ack,
  output logic        busy
);
  logic [6:0] sclk_divider_q, sclk_divider_d;
  logic [5:0] stage_q, stage_d;
  logic       clock_en_q, clock_en_d;
  logic       sda_low_q, sda_low_d;
  logic [2:0] acks_q, acks_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] w_byte, r_byte;
  logic       tx_bit, nack, sda_in, unused_bits;
  assign w_byte = {addr_q, 1'b0};
  assign r_byte = {addr_q, 1'b1};
  assign sda_in = i2c_sdat;
  assign unused_bits = ^{i2c_data[31:23], i2c_data[7:0]};
`ifdef I2C_RD_NACK_ABORT_EN
  assign nack = (stage_q == 6'd9 && acks_q[0]) || (stage_q == 6'd18 && acks_q[1]) ||
                (stage_q == 6'd29 && acks_q[2]);
`else
  assign nack = 1'b0;
`endif
  // Level the master puts on SDA at mid-low of each stage (1 = released)
  always_comb begin
    tx_bit = stage_q == 6'd0  ? 1'b0 :
             stage_q <= 6'd8  ? w_byte[3'(6'd8 - stage_q)] :
             stage_q <= 6'd9  ? 1'b1 :
             stage_q <= 6'd17 ? ptr_q[3'(6'd17 - stage_q)] :
             stage_q <= 6'd19 ? 1'b1 :
             stage_q == 6'd20 ? 1'b0 :
             stage_q <= 6'd28 ? r_byte[3'(6'd28 - stage_q)] :
             stage_q == 6'd39 ? 1'b0 : 1'b1;
  end
  always_comb begin
    sclk_divider_d = sclk_divider_q;
    stage_d        = stage_q;
    clock_en_d     = clock_en_q;
    sda_low_d      = sda_low_q;
    acks_d         = acks_q;
    shift_d        = shift_q;
    rd_data_d      = rd_data_q;
    done_d         = done_q;
    busy_d         = busy_q;
    addr_d         = addr_q;
    ptr_d          = ptr_q;
    if (!busy_q) begin
      if (start) begin
        addr_d         = i2c_data[22:16];
        ptr_d          = i2c_data[15:8];
        sclk_divider_d = 7'd0;
        stage_d        = 6'd0;
        clock_en_d     = 1'b0;
        sda_low_d      = 1'b0;
        acks_d         = 3'b111;
        done_d         = 1'b0;
        busy_d         = 1'b1;
      end
    end else begin
      sclk_divider_d = sclk_divider_q + 7'd1;
      if (sclk_divider_q == 7'd31) sda_low_d = !tx_bit;
      if (sclk_divider_q == 7'd95) begin
        if (stage_q == 6'd9) acks_d[0] = sda_in;
        if (stage_q == 6'd18) acks_d[1] = sda_in;
        if (stage_q == 6'd29) acks_d[2] = sda_in;
        if (stage_q >= 6'd30 && stage_q <= 6'd37) shift_d = {shift_q[6:0], sda_in};
      end
      if (sclk_divider_q == 7'd127) begin
        stage_d    = nack ? 6'd39 : stage_q == LAST_STAGE ? stage_q : stage_q + 6'd1;
        clock_en_d = (stage_q == 6'd0 || stage_q == 6'd20) ? 1'b1 :
                     (stage_q == 6'd19 || stage_q == 6'd39) ? 1'b0 : clock_en_q;
        if (stage_q == 6'd37) rd_data_d = shift_q;
        if (stage_q == 6'd40) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_divider_q <= 7'd0;
      stage_q        <= LAST_STAGE;
      clock_en_q     <= 1'b0;
      sda_low_q      <= 1'b0;
      acks_q         <= 3'b111;
      shift_q        <= 8'd0;
      rd_data_q      <= 8'd0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
      addr_q         <= 7'd0;
      ptr_q          <= 8'd0;
    end else begin
      sclk_divider_q <= sclk_divider_d;
      stage_q        <= stage_d;
      clock_en_q     <= clock_en_d;
      sda_low_q      <= sda_low_d;
      acks_q         <= acks_d;
      shift_q        <= shift_d;
      rd_data_q      <= rd_data_d;
      done_q         <= done_d;
      busy_q         <= busy_d;
      addr_q         <= addr_d;
      ptr_q          <= ptr_d;
    end
  end
  assign i2c_sclk = !clock_en_q || sclk_divider_q[6];
  assign i2c_sdat = sda_low_q ? 1'b0 : 1'bz;
  assign rd_data  = rd_data_q;
  assign done     = done_q;
  assign ack      = acks_q == 3'b000;
  assign busy     = busy_q;
endmodule

// File: tb/tb_i2c_controller_read.sv
// tb_i2c_controller_read: bus-decoding slave model plus a scoreboard of per-transaction expectations.
module tb_i2c_controller_read;
  logic        clk = 0;
  logic        reset, start;
  logic [31:0] i2c_data;
  logic        i2c_sclk;
  wire         sda_bus;
  logic [7:0]  rd_data;
  logic        done, ack, busy;

  i2c_controller_read dut (
    .clk(clk), .reset(reset), .start(start), .i2c_data(i2c_data),
    .i2c_sclk(i2c_sclk), .i2c_sdat(sda_bus), .rd_data(rd_data),
    .done(done), .ack(ack), .busy(busy)
  );

  always #5 clk = ~clk;

  bit s_low = 0;
  assign sda_bus = s_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  typedef struct {
    logic [7:0] rd;
    logic       ack;
    int         lat;
    int         nb;
    int         ns;
  } exp_t;
  exp_t q[$];

  localparam logic [7:0] EB [3] = '{8'h34, 8'h05, 8'h35};

  int n_chk = 0, n_fail = 0;
  int cyc = 0, t0 = 0, n_done = 0;
  int n_start = 0, n_stop = 0;
  logic [7:0] bq[$];
  logic [7:0] prev_rd = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Slave: decodes START/STOP and bits from the bus, acks its address and the pointer, returns s_data
  bit         s_present = 1;
  logic [6:0] s_addr = 7'h1A;
  logic [7:0] s_data = 8'h00;
  logic [7:0] rx = 0;
  int         bitcnt = 0, fbytes = 0;
  bit         tx_mode = 0, go_tx = 0, scl_p = 1, sda_p = 1;
  always @(negedge clk) begin
    if (scl_p && i2c_sclk && sda_p && !sda_bus) begin
      n_start++; bitcnt = 0; fbytes = 0; tx_mode = 0; go_tx = 0; s_low = 0;
    end else if (scl_p && i2c_sclk && !sda_p && sda_bus) begin
      n_stop++; bitcnt = 0; fbytes = 0; tx_mode = 0; go_tx = 0; s_low = 0;
    end else if (!scl_p && i2c_sclk) begin
      if (bitcnt < 8) rx = {rx[6:0], sda_bus};
      bitcnt++;
      if (bitcnt == 9 && tx_mode && sda_bus) tx_mode = 0;
    end else if (scl_p && !i2c_sclk) begin
      if (bitcnt == 8) begin
        if (!tx_mode) begin
          bq.push_back(rx);
          s_low = s_present && (fbytes > 0 || rx[7:1] == s_addr);
          go_tx = s_low && fbytes == 0 && rx[0];
          fbytes++;
        end else s_low = 0;
      end else if (bitcnt == 9) begin
        bitcnt = 0;
        if (go_tx) begin tx_mode = 1; go_tx = 0; end
        s_low = tx_mode && !s_data[7];
      end else if (tx_mode) s_low = !s_data[3'(7 - bitcnt)];
    end
    scl_p = i2c_sclk;
    sda_p = sda_bus;
  end

  // Scoreboard consumer: each rising done pops one expectation
  logic done_p = 0;
  always @(negedge clk) begin
    exp_t e;
    if (done && !done_p) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("rd_data", rd_data, e.rd);
        chk("ack", ack, e.ack);
        chk("busy_end", busy, 0);
        chk("latency", cyc - t0, e.lat);
        chk("n_start", n_start, e.ns);
        chk("n_stop", n_stop, 1);
        for (int i = 0; i < e.nb; i++)
          chk("bus_byte", i < bq.size() ? 32'(bq[i]) : 32'hDEAD, 32'(EB[i]));
      end
      n_done++;
    end
    done_p = done;
  end

  task automatic wait_done();
    int n0 = n_done;
    for (int i = 0; i < 6000 && n_done == n0; i++) @(negedge clk);
    if (n_done == n0) chk("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic run(input logic [7:0] d, input bit present, input int pulse_at);
    exp_t e;
    s_data = d; s_present = present; n_start = 0; n_stop = 0; bq.delete();
    e.rd = d; e.ack = present; e.lat = 41 * 128; e.nb = 3; e.ns = 2;
    if (!present) begin
      e.rd = 8'hFF;
`ifdef I2C_RD_NACK_ABORT_EN
      e.rd = prev_rd; e.lat = 12 * 128; e.nb = 1; e.ns = 1;
`endif
    end
    prev_rd = e.rd;
    q.push_back(e);
    i2c_data = {9'h1FF, 7'h1A, 8'h05, 8'hC3};
    start = 1;
    @(negedge clk);
    start = 0; t0 = cyc;
    chk("busy_rise", busy, 1);
    chk("done_drop", done, 0);
    if (pulse_at > 0) begin
      repeat (pulse_at * 128) @(negedge clk);
      i2c_data = 32'h0;
      start = 1;
      @(negedge clk);
      start = 0;
      chk("busy_ignore", busy, 1);
    end
    wait_done();
  endtask

  initial begin
    reset = 1; start = 0; i2c_data = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_sclk", i2c_sclk, 1);
    chk("rst_sda", sda_bus, 1);
    chk("rst_rd", rd_data, 0);
    chk("rst_done", done, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    run(8'hA5, 1, 0);
    run(8'h00, 1, 0);
    chk("done_hold", done, 1);
    run(8'hFF, 1, 0);
    run(8'hA5, 1, 15);
    run(8'h77, 0, 0);
    // Reset partway into the data byte, with start asserted in the same cycle
    s_data = 8'hFF; s_present = 1; n_start = 0; n_stop = 0; bq.delete();
    i2c_data = {9'h0, 7'h1A, 8'h05, 8'h00};
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (33 * 128) @(negedge clk);
    reset = 1; start = 1;
    @(negedge clk);
    reset = 0; start = 0;
    chk("mid_rst_sclk", i2c_sclk, 1);
    chk("mid_rst_sda", sda_bus, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rd", rd_data, 0);
    prev_rd = 8'h00;
    repeat (20) @(negedge clk);
    chk("mid_rst_idle", busy, 0);
    run(8'h5A, 1, 0);
    chk("sb_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
